// File: rtl/ysyx_040729_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_040729_lsu -- load/store unit between the pipeline and a 64-bit,
// combinational-read byte-addressed memory block.
//
// One operation is in flight at a time. Loads read the 8 bytes at the
// request address and return the low 1/2/4/8 bytes, zero- or sign-extended.
// Double stores write the 8 bytes directly. Narrower stores do a
// read-modify-write: read the 8 bytes, replace the low bytes, write back.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/ready   : request handshake (ready only in IDLE, outside reset)
//   req_wen           : 1 = store, 0 = load
//   req_size          : 0 byte, 1 half, 2 word, 3 double
//   req_unsigned      : load zero-extends when set, sign-extends otherwise
//   req_addr/wdata    : byte address (any alignment), store data (low bytes)
//   resp_valid/ready  : response handshake, resp_rdata = load result or 0
//   mem_wen/addr/wdata: memory write strobe, address, 8-byte write data
//   mem_rdata         : memory read data, combinational from mem_addr
// ---------------------------------------------------------------------------

// Per-byte-lane datapath: store merge for read-modify-write and load
// extension. A lane is "active" when it lies inside the access size.
module ysyx_040729_lsu_lane #(
    parameter int LANE = 0
) (
    input  logic [1:0] size,
    input  logic [7:0] wbyte,
    input  logic [7:0] rbyte,
    input  logic [7:0] fill,
    output logic [7:0] merged,
    output logic [7:0] ext
);
    logic active;

    assign active = (4'(LANE) < (4'd1 << size));
    // store: new byte in active lanes, memory byte above
    assign merged = active ? wbyte : rbyte;
    // load: memory byte in active lanes, extension fill above
    assign ext    = active ? rbyte : fill;
endmodule

module ysyx_040729_lsu #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int NUM_LANES = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        RMW_RD,
        RMW_WR,
        RESP
    } state_t;

    typedef struct packed {
        logic                  wen;
        logic [1:0]            size;
        logic                  uns;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    state_t                state;
    req_t                  req_q;
    logic                  drive_q;      // mem_addr carries req_q.addr
    logic                  mem_wen_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;

    logic                  hs;
    logic                  sign;
    logic [7:0]            fill;
    logic [NUM_LANES-1:0][7:0] merged;
    logic [NUM_LANES-1:0][7:0] ext;

    assign req_ready = (state == IDLE) && !rst;
    assign hs        = req_valid && req_ready;

    // Sign bit of the accessed element; size 3 has no fill lanes.
    always_comb begin
        sign = 1'b0;
        case (req_q.size)
            2'd0:    sign = mem_rdata[7];
            2'd1:    sign = mem_rdata[15];
            2'd2:    sign = mem_rdata[31];
            default: sign = 1'b0;
        endcase
    end
    assign fill = {8{sign & ~req_q.uns}};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        ysyx_040729_lsu_lane #(
            .LANE(i)
        ) u_lane (
            .size  (req_q.size),
            .wbyte (req_q.wdata[8*i +: 8]),
            .rbyte (mem_rdata[8*i +: 8]),
            .fill  (fill),
            .merged(merged[i]),
            .ext   (ext[i])
        );
    end

    // Control and all outputs are registered; the output stage below only
    // forces them to zero during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            req_q        <= '0;
            drive_q      <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        req_q   <= '{wen: req_wen, size: req_size, uns: req_unsigned,
                                     addr: req_addr, wdata: req_wdata};
                        drive_q <= 1'b1;
                        if (!req_wen) begin
                            state <= LOAD;
                        end else if (req_size == 2'd3) begin
                            // full-width store needs no merge
                            state       <= WRITE;
                            mem_wen_q   <= 1'b1;
                            mem_wdata_q <= req_wdata;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    state        <= RESP;
                    drive_q      <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= req_q.wen ? '0 : ext;
                end
                RMW_RD: begin
                    state       <= RMW_WR;
                    mem_wen_q   <= 1'b1;
                    mem_wdata_q <= merged;
                end
                WRITE, RMW_WR: begin
                    state        <= RESP;
                    drive_q      <= 1'b0;
                    mem_wen_q    <= 1'b0;
                    mem_wdata_q  <= '0;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= '0;
                end
                RESP: begin
                    if (resp_ready) begin
                        state        <= IDLE;
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= '0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    drive_q      <= 1'b0;
                    mem_wen_q    <= 1'b0;
                    mem_wdata_q  <= '0;
                    resp_valid_q <= 1'b0;
                    resp_rdata_q <= '0;
                end
            endcase
        end
    end

    // Reset blanks every output immediately, so a reset landing in RMW_WR
    // suppresses that cycle's write.
    assign mem_wen    = mem_wen_q && !rst;
    assign mem_addr   = (rst || !drive_q) ? '0 : req_q.addr;
    assign mem_wdata  = rst ? '0 : mem_wdata_q;
    assign resp_valid = resp_valid_q && !rst;
    assign resp_rdata = rst ? '0 : resp_rdata_q;
endmodule

// File: tb/tb_ysyx_040729_lsu.sv
module tb_ysyx_040729_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [15:0] req_addr = 16'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        mem_wen;
    logic [15:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    logic [7:0] mem     [65536];   // memory seen by the DUT
    logic [7:0] ref_mem [65536];   // reference model memory

    typedef struct {
        logic [63:0] rdata;
        logic [63:0] wdata;
        logic [15:0] addr;
        int          hs;
        int          lat;
        int          wr_lat;
        int          nwr;
    } exp_t;
    exp_t q[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int rr_mode = 1;   // 0 random, 1 always ready, 2 never ready
    int wr_cnt = 0;
    bit in_resp = 1'b0;

    ysyx_040729_lsu #(.ADDR_WIDTH(16), .DATA_WIDTH(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(posedge clk);
        #1;
        case (rr_mode)
            0:       resp_ready = ($urandom_range(0, 3) != 0);
            1:       resp_ready = 1'b1;
            default: resp_ready = 1'b0;
        endcase
    end

    always_comb begin
        mem_rdata = 64'd0;
        for (int i = 0; i < 8; i++) mem_rdata[8*i +: 8] = mem[mem_addr + 16'(i)];
    end

    always @(posedge clk) begin
        if (mem_wen)
            for (int i = 0; i < 8; i++) mem[mem_addr + 16'(i)] = mem_wdata[8*i +: 8];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic bail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=completion within bound", nm);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // Scoreboard monitor: samples on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_outputs", {58'd0, req_ready, resp_valid, mem_wen, |resp_rdata,
                                |mem_addr, |mem_wdata}, 64'h0);
        end else if (q.size() == 0) begin
            chk("idle_outputs", {58'd0, req_ready, resp_valid, mem_wen, |resp_rdata,
                                 |mem_addr, |mem_wdata}, 64'h20);
        end else begin
            chk("busy_req_ready", 64'(req_ready), 64'h0);
            if (mem_wen) begin
                chk("wr_cycle", 64'(cyc - q[0].hs), 64'(q[0].wr_lat));
                chk("wr_addr", 64'(mem_addr), 64'(q[0].addr));
                chk("wr_data", mem_wdata, q[0].wdata);
                wr_cnt++;
            end
            if (resp_valid) begin
                if (!in_resp) begin
                    chk("resp_latency", 64'(cyc - q[0].hs), 64'(q[0].lat));
                    in_resp = 1'b1;
                end
                chk("resp_rdata", resp_rdata, q[0].rdata);
                if (resp_ready) begin
                    chk("write_count", 64'(wr_cnt), 64'(q[0].nwr));
                    void'(q.pop_front());
                    in_resp = 1'b0;
                    wr_cnt  = 0;
                end
            end else if (in_resp) begin
                chk("resp_held", 64'(resp_valid), 64'h1);
            end
        end
    end

    // Reference model: expected result straight from the byte-level rules.
    task automatic issue(input bit wen, input logic [1:0] size, input bit uns,
                         input logic [15:0] addr, input logic [63:0] wdata,
                         input bit commit, input bit ovr, input logic [63:0] ovr_val);
        exp_t e;
        int n;
        int t;
        logic [63:0] v;
        logic [7:0] b [8];
        n = 1 << size;
        t = 0;
        @(negedge clk);
        while (!req_ready) begin
            t++;
            if (t > 50) begin bail("req_ready_wait"); return; end
            @(negedge clk);
        end
        req_valid = 1'b1; req_wen = wen; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        e.hs = cyc;
        e.addr = addr;
        for (int i = 0; i < 8; i++) b[i] = ref_mem[addr + 16'(i)];
        v = 64'd0;
        if (!wen) begin
            for (int i = 0; i < n; i++) v |= 64'(b[i]) << (8*i);
            if (!uns && n < 8 && v[8*n-1]) v |= ~((64'd1 << (8*n)) - 64'd1);
            e.rdata = ovr ? ovr_val : v;
            e.wdata = 64'd0; e.lat = 2; e.wr_lat = 0; e.nwr = 0;
        end else begin
            for (int i = 0; i < n; i++) b[i] = wdata[8*i +: 8];
            for (int i = 0; i < 8; i++) v |= 64'(b[i]) << (8*i);
            if (commit) for (int i = 0; i < n; i++) ref_mem[addr + 16'(i)] = b[i];
            e.rdata = 64'd0;
            e.wdata = ovr ? ovr_val : v;
            e.lat = (size == 2'd3) ? 2 : 3;
            e.wr_lat = (size == 2'd3) ? 1 : 2;
            e.nwr = 1;
        end
        @(posedge clk);
        q.push_back(e);
    endtask

    task automatic wait_done(input bit junk);
        int t = 0;
        forever begin
            @(negedge clk);
            if (q.size() == 0) break;
            t++;
            if (t > 60) begin bail("resp_wait"); break; end
            if (junk) begin
                req_valid = 1'($urandom_range(0, 1));
                req_wen = 1'($urandom_range(0, 1));
                req_size = 2'($urandom_range(0, 3));
                req_unsigned = 1'($urandom_range(0, 1));
                req_addr = 16'($urandom);
                req_wdata = {$urandom, $urandom};
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] wd;
        logic [15:0] ad;
        logic [63:0] got;
        int bad;
        for (int a = 0; a < 65536; a++) begin
            mem[a] = 8'($urandom);
            ref_mem[a] = mem[a];
        end
        wd = 64'h8877665544332211;
        for (int i = 0; i < 8; i++) begin
            mem[16'h10 + i] = wd[8*i +: 8];
            ref_mem[16'h10 + i] = wd[8*i +: 8];
        end

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // byte / word loads, signed and unsigned, misaligned
        issue(0, 2'd0, 0, 16'h0017, 64'd0, 1, 1, 64'hFFFFFFFFFFFFFF88); wait_done(0);
        issue(0, 2'd0, 1, 16'h0017, 64'd0, 1, 1, 64'h0000000000000088); wait_done(1);
        issue(0, 2'd2, 0, 16'h0013, 64'd0, 1, 1, 64'h0000000077665544); wait_done(1);
        issue(0, 2'd2, 1, 16'h0013, 64'd0, 1, 1, 64'h0000000077665544); wait_done(1);
        // half store via read-modify-write, then readback
        issue(1, 2'd1, 0, 16'h0010, 64'h0000DEADBEEFCAFE, 1, 1, 64'h887766554433CAFE); wait_done(1);
        issue(0, 2'd3, 0, 16'h0010, 64'd0, 1, 1, 64'h887766554433CAFE); wait_done(0);
        // double store, then readback
        issue(1, 2'd3, 0, 16'h0020, 64'h0123456789ABCDEF, 1, 1, 64'h0123456789ABCDEF); wait_done(1);
        issue(0, 2'd3, 1, 16'h0020, 64'd0, 1, 1, 64'h0123456789ABCDEF); wait_done(0);
        // address wrap past the top of memory
        issue(0, 2'd3, 0, 16'hFFFC, 64'd0, 1, 0, 64'd0); wait_done(0);
        issue(1, 2'd2, 0, 16'hFFFE, 64'hA5A5A5A5F00DBEEF, 1, 0, 64'd0); wait_done(0);

        // response held back; requests during RESP must be ignored
        rr_mode = 2;
        issue(0, 2'd3, 0, 16'h0010, 64'd0, 1, 1, 64'h887766554433CAFE);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k >= 2) chk("hold_resp_valid", 64'(resp_valid), 64'h1);
            req_valid = 1'b1; req_wen = 1'b1; req_size = 2'd3;
            req_addr = 16'h0010; req_wdata = 64'h0;
        end
        req_valid = 1'b0;
        rr_mode = 1;
        wait_done(0);

        // reset during the write cycle of a byte store
        issue(1, 2'd0, 0, 16'h0010, 64'h00000000000000AA, 0, 0, 64'd0);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        wr_cnt = 0;
        in_resp = 1'b0;
        @(negedge clk);
        chk("rst_then_ready", 64'(req_ready), 64'h1);
        for (int i = 0; i < 8; i++) got[8*i +: 8] = mem[16'h10 + i];
        chk("rst_no_write", got, 64'h887766554433CAFE);

        // randomized traffic with random back-pressure
        rr_mode = 0;
        repeat (300) begin
            ad = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15))
                                             : 16'($urandom_range(0, 63));
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ad, {$urandom, $urandom}, 1, 0, 64'd0);
            wait_done(1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        rr_mode = 1;
        repeat (3) @(negedge clk);

        bad = 0;
        for (int a = 0; a < 65536; a++) if (mem[a] !== ref_mem[a]) bad++;
        chk("mem_final_mismatch_bytes", 64'(bad), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
